uart_rx_unit: RTL and testbench
===============================

// Module: uart_rx_unit
// PURPOSE
// - Serial UART receiver, 8N1, LSB first, 16x oversampled by an external baud tick (baudrate_generator).
// - Sits between the board RX pin and the debug/loader unit of the mips core.
// - Delivers each received byte with a one-cycle valid strobe.
// - Also exposes status (state, frame-in-progress, framing error).
// PARAMETERS
// - N            8   data bits per frame
// - COUNT_TICKS  16  baud ticks per bit; must be even and >= 4
// PORTS
// - clk         in   1  system clock; all logic on rising edge
// - reset       in   1  asynchronous, active-low reset (0 = reset)
// - tick        in   1  one-clk-wide baud enable, COUNT_TICKS per bit period
// - rx          in   1  serial line; idle high; asynchronous to clk
// - data_out    out  N  last correctly framed byte; held until the next good frame
// - valid       out  1  one-clk pulse: data_out updated this cycle
// - frame_err   out  1  one-clk pulse: stop bit sampled low
// - state_leds  out  4  one-hot state: IDLE=0001, START=0010, DATA=0100, STOP=1000
// - started     out  1  high while state != IDLE
// BEHAVIOUR
// - Reset values: data_out=0, valid=0, frame_err=0, state_leds=0001, started=0; synchroniser flops reset to 1.
// - rx passes through a 2-flop synchroniser (2 clk latency); the FSM sees only rx_s.
// - All counters advance only in clk cycles with tick=1. valid and frame_err never last more than 1 clk.
// - IDLE: when rx_s==0 (any clk) -> START; tick_cnt=0.
// - START: on each tick, if tick_cnt==COUNT_TICKS/2-1, sample rx_s:
//   - 0 -> DATA; tick_cnt=0, bit_cnt=0.
//   - 1 -> false start; go IDLE, no strobe.
//   - Otherwise tick_cnt++.
// - DATA: on each tick, if tick_cnt==COUNT_TICKS-1 (mid-bit):
//   - shift sample in at MSB (shreg={s,shreg[N-1:1]}), so the first bit lands in bit 0.
//   - tick_cnt=0; if bit_cnt==N-1 -> STOP, else bit_cnt++.
// - STOP: at tick_cnt==COUNT_TICKS-1, sample:
//   - 1 -> data_out<=shreg, valid=1.
//   - 0 -> frame_err=1, data_out unchanged.
//   - Either way go IDLE in the same cycle.
// - Back-to-back frames: a new start bit is accepted immediately after STOP (no extra idle time needed).
// - Reset asserted mid-frame: FSM to IDLE at once; partial byte discarded, no strobe.
// - A tick in the same cycle as the rx falling edge has no extra effect; the start count begins at the next tick.
// - Line stuck low (break): each frame ends in frame_err; reception restarts from IDLE.
// CONFIGURATION
// - `UART_RX_MAJORITY_EN` defined:
//   - a 3-bit history of rx_s is shifted on every tick.
//   - each sample (start, data, stop) = majority of the last 3 ticks.
//   - a one-tick glitch at mid-bit is rejected.
// - Not defined: each sample = rx_s on the sampling tick (single sample).
// - Timing is identical in both builds.
// STRUCTURE
// - Package uart_pkg holds:
//   - state enum IDLE/START/DATA/STOP with one-hot encodings.
//   - localparams HALF=COUNT_TICKS/2-1, FULL=COUNT_TICKS-1.
//   - counter width helper $clog2(COUNT_TICKS).
// - One sub-module: uart_sync2 (2-flop synchroniser, reset value 1).
// - The FSM, counters, shift register and majority filter stay in uart_rx_unit.
// TESTING
// - Tick source: tick=1 every 4th clk (fast sim) and, separately, baud divider 326 @100MHz (~19200 baud).
// - Send 0x55 8N1:
//   - expect exactly one valid pulse, data_out=0x55, frame_err never 1.
//   - state_leds passes 0001->0010->0100->1000->0001.
// - Send 0x08, 0x07, 0x0F back-to-back with no idle gap -> three valid pulses, data_out 0x08, then 0x07, then 0x0F.
// - rx low for 4 ticks, then high (false start) -> back to IDLE before mid-start; no valid, no frame_err; started falls.
// - Frame 0xA5 with stop bit forced 0 -> frame_err pulse, no valid, data_out keeps the previous value; next good 0x3C is received correctly.
// - Reset (reset=0) during bit 4 of a frame:
//   - outputs return to their reset values immediately.
//   - after release, the rest of the interrupted frame produces no valid; the next good 0x11 frame gives valid with data_out=0x11.
// - With UART_RX_MAJORITY_EN: one-tick low glitch at mid-bit of a 1 bit in 0xFF -> data_out=0xFF.
//   Without the macro, the same stimulus gives data_out=0xF7 when the glitch is on bit 3.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and timing constants for the UART receiver.
// Optional build macro: UART_RX_MAJORITY_EN (3-tick majority sampling in uart_rx_unit).
package uart_pkg;

  localparam int unsigned DEF_N           = 8;
  localparam int unsigned DEF_COUNT_TICKS = 16;

  // Tick index of the mid-start sample and of each later mid-bit sample.
  function automatic int unsigned half_tick(input int unsigned count_ticks);
    return count_ticks / 2 - 1;
  endfunction

  function automatic int unsigned full_tick(input int unsigned count_ticks);
    return count_ticks - 1;
  endfunction

  // Width of the per-bit tick counter.
  function automatic int unsigned cnt_width(input int unsigned count_ticks);
    return $clog2(count_ticks);
  endfunction

  localparam int unsigned HALF = half_tick(DEF_COUNT_TICKS);
  localparam int unsigned FULL = full_tick(DEF_COUNT_TICKS);

  // Majority vote of three samples.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // One-hot so the state register drives the status LEDs directly.
  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  // Resets to the idle line level so no spurious start bit is seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver, LSB first, oversampled by an external baud tick.
// Optional build macro: UART_RX_MAJORITY_EN (each sample is the majority of the last 3 ticks).
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int unsigned N           = DEF_N,
  parameter int unsigned COUNT_TICKS = DEF_COUNT_TICKS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         rx,
  output logic [N-1:0] data_out,
  output logic         valid,
  output logic         frame_err,
  output logic [3:0]   state_leds,
  output logic         started
);

  localparam int unsigned CW        = cnt_width(COUNT_TICKS);
  localparam int unsigned BW        = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned HALF_TICK = half_tick(COUNT_TICKS);
  localparam int unsigned FULL_TICK = full_tick(COUNT_TICKS);

  logic          rx_s;
  logic          sample_c;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [N-1:0]  data_d;
  logic          valid_d, ferr_d, started_d;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  logic [2:0] hist_c;

  // Window is the two previous ticks plus the current one, so sample timing matches the single-sample build.
  assign hist_c   = {hist_q, rx_s};
  assign sample_c = maj3(hist_c);

  // Line history, advanced once per tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= 2'b11;
    end else if (tick) begin
      hist_q <= hist_c[1:0];
    end
  end
`else
  assign sample_c = rx_s;
`endif

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      data_out   <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      started    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      data_out   <= data_d;
      valid      <= valid_d;
      frame_err  <= ferr_d;
      started    <= started_d;
    end
  end

  // Next-state and output decode; strobes default low so they last one clock.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    data_d     = data_out;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == CW'(HALF_TICK)) begin
            if (!sample_c) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == CW'(FULL_TICK)) begin
            shreg_d    = {sample_c, shreg_q[N-1:1]};
            tick_cnt_d = '0;
            if (bit_cnt_q == BW'(N - 1)) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == CW'(FULL_TICK)) begin
            if (sample_c) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    started_d = (state_d != IDLE);
  end

  assign state_leds = state_q;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed testbench for uart_rx_unit (8N1, 16 ticks per bit).
module tb_uart_rx_unit;

  localparam int unsigned TPB = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       tick;
  logic [7:0] data_out;
  logic       valid, frame_err, started;
  logic [3:0] state_leds;

  int unsigned div  = 4;
  int unsigned tcnt = 0;

  int n_vec = 0;
  int n_err = 0;

  int         valid_cnt = 0;
  int         ferr_cnt  = 0;
  int         long_cnt  = 0;
  logic [7:0] data_log[$];
  logic [3:0] state_log[$];
  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;
  logic [3:0] prev_state = 4'b0001;

  uart_rx_unit #(.N(8), .COUNT_TICKS(16)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .tick       (tick),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .frame_err  (frame_err),
    .state_leds (state_leds),
    .started    (started)
  );

  always #5 clk = ~clk;

  // Baud tick: one clock in every div clocks.
  always @(posedge clk) tcnt <= (tcnt >= div - 1) ? 0 : tcnt + 1;
  assign tick = (tcnt == div - 1);

  // Passive recorder of strobes and state changes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        valid_cnt++;
        data_log.push_back(data_out);
      end
      if (frame_err) ferr_cnt++;
      if ((valid && prev_valid) || (frame_err && prev_ferr)) long_cnt++;
    end
    if (state_leds !== prev_state) state_log.push_back(state_leds);
    prev_valid = valid;
    prev_ferr  = frame_err;
    prev_state = state_leds;
  end

  task automatic clear_mon();
    valid_cnt = 0;
    ferr_cnt  = 0;
    data_log.delete();
    state_log.delete();
  endtask

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Start each frame on a known tick phase.
  task automatic align();
    while (tcnt != 0) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int unsigned nclk);
    rx = b;
    repeat (nclk) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    align();
    drive_bit(1'b0, TPB * div);
    for (int i = 0; i < 8; i++) drive_bit(b[i], TPB * div);
    drive_bit(stop_bit, TPB * div);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", data_out); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", valid); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
    n_vec++; if (state_leds !== 4'b0001) begin n_err++; $display("FAIL rst_state: got %b want 0001", state_leds); end
    n_vec++; if (started !== 1'b0) begin n_err++; $display("FAIL rst_started: got %b want 0", started); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_55();
    logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    div = 326;
    idle(10);
    clear_mon();
    send_frame(8'h55, 1'b1);
    idle(200);
    n_vec++; if (valid_cnt != 1) begin n_err++; $display("FAIL b55_valid_count: got %0d want 1", valid_cnt); end
    n_vec++; if (data_out !== 8'h55) begin n_err++; $display("FAIL b55_data: got %h want 55", data_out); end
    n_vec++; if (ferr_cnt != 0) begin n_err++; $display("FAIL b55_ferr_count: got %0d want 0", ferr_cnt); end
    n_vec++; if (state_log.size() != 4) begin n_err++; $display("FAIL b55_state_steps: got %0d want 4", state_log.size()); end
    if (state_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (state_log[i] !== exp_seq[i]) begin
          n_err++; $display("FAIL b55_state_%0d: got %b want %b", i, state_log[i], exp_seq[i]);
        end
      end
    end
    div = 4;
    idle(20);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [3] = '{8'h08, 8'h07, 8'h0F};
    clear_mon();
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
    idle(100);
    n_vec++; if (valid_cnt != 3) begin n_err++; $display("FAIL b2b_valid_count: got %0d want 3", valid_cnt); end
    if (data_log.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (data_log[i] !== exp_b[i]) begin
          n_err++; $display("FAIL b2b_data_%0d: got %h want %h", i, data_log[i], exp_b[i]);
        end
      end
    end
    n_vec++; if (ferr_cnt != 0) begin n_err++; $display("FAIL b2b_ferr_count: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_false_start();
    clear_mon();
    align();
    drive_bit(1'b0, 4 * div);
    drive_bit(1'b1, 4);
    n_vec++; if (started !== 1'b1) begin n_err++; $display("FAIL fs_started_hi: got %b want 1", started); end
    n_vec++; if (state_leds !== 4'b0010) begin n_err++; $display("FAIL fs_state_start: got %b want 0010", state_leds); end
    drive_bit(1'b1, 40);
    n_vec++; if (state_leds !== 4'b0001) begin n_err++; $display("FAIL fs_state_idle: got %b want 0001", state_leds); end
    n_vec++; if (started !== 1'b0) begin n_err++; $display("FAIL fs_started_lo: got %b want 0", started); end
    idle(100);
    n_vec++; if (valid_cnt != 0) begin n_err++; $display("FAIL fs_valid_count: got %0d want 0", valid_cnt); end
    n_vec++; if (ferr_cnt != 0) begin n_err++; $display("FAIL fs_ferr_count: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_frame_error();
    logic [7:0] b = 8'hA5;
    clear_mon();
    align();
    drive_bit(1'b0, TPB * div);
    for (int i = 0; i < 8; i++) drive_bit(b[i], TPB * div);
    // Low stop bit, released before the receiver's re-armed start check.
    drive_bit(1'b0, 12 * div);
    drive_bit(1'b1, 4 * div);
    idle(128);
    n_vec++; if (ferr_cnt != 1) begin n_err++; $display("FAIL fe_ferr_count: got %0d want 1", ferr_cnt); end
    n_vec++; if (valid_cnt != 0) begin n_err++; $display("FAIL fe_valid_count: got %0d want 0", valid_cnt); end
    n_vec++; if (data_out !== 8'h0F) begin n_err++; $display("FAIL fe_data_held: got %h want 0f", data_out); end
    clear_mon();
    send_frame(8'h3C, 1'b1);
    idle(100);
    n_vec++; if (valid_cnt != 1) begin n_err++; $display("FAIL fe_next_valid_count: got %0d want 1", valid_cnt); end
    n_vec++; if (data_out !== 8'h3C) begin n_err++; $display("FAIL fe_next_data: got %h want 3c", data_out); end
    n_vec++; if (ferr_cnt != 0) begin n_err++; $display("FAIL fe_next_ferr_count: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b = 8'hF0;
    clear_mon();
    align();
    drive_bit(1'b0, TPB * div);
    for (int i = 0; i < 4; i++) drive_bit(b[i], TPB * div);
    drive_bit(b[4], 32);
    rst_n = 1'b0;
    #1;
    n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL mr_data: got %h want 00", data_out); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL mr_valid: got %b want 0", valid); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL mr_ferr: got %b want 0", frame_err); end
    n_vec++; if (state_leds !== 4'b0001) begin n_err++; $display("FAIL mr_state: got %b want 0001", state_leds); end
    n_vec++; if (started !== 1'b0) begin n_err++; $display("FAIL mr_started: got %b want 0", started); end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    drive_bit(b[4], 28);
    for (int i = 5; i < 8; i++) drive_bit(b[i], TPB * div);
    drive_bit(1'b1, TPB * div);
    idle(64);
    n_vec++; if (valid_cnt != 0) begin n_err++; $display("FAIL mr_tail_valid_count: got %0d want 0", valid_cnt); end
    n_vec++; if (ferr_cnt != 0) begin n_err++; $display("FAIL mr_tail_ferr_count: got %0d want 0", ferr_cnt); end
    n_vec++; if (state_leds !== 4'b0001) begin n_err++; $display("FAIL mr_tail_state: got %b want 0001", state_leds); end
    clear_mon();
    send_frame(8'h11, 1'b1);
    idle(100);
    n_vec++; if (valid_cnt != 1) begin n_err++; $display("FAIL mr_next_valid_count: got %0d want 1", valid_cnt); end
    n_vec++; if (data_out !== 8'h11) begin n_err++; $display("FAIL mr_next_data: got %h want 11", data_out); end
  endtask

  task automatic test_glitch();
    logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
    exp_d = 8'hFF;
`else
    exp_d = 8'hF7;
`endif
    clear_mon();
    align();
    drive_bit(1'b0, TPB * div);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, TPB * div);
    // Bit 3: low for exactly the one tick on which the mid-bit sample is taken.
    drive_bit(1'b1, 26);
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 34);
    for (int i = 4; i < 8; i++) drive_bit(1'b1, TPB * div);
    drive_bit(1'b1, TPB * div);
    idle(100);
    n_vec++; if (valid_cnt != 1) begin n_err++; $display("FAIL gl_valid_count: got %0d want 1", valid_cnt); end
    n_vec++; if (data_out !== exp_d) begin n_err++; $display("FAIL gl_data: got %h want %h", data_out, exp_d); end
  endtask

  initial begin
    test_reset();
    test_single_55();
    test_back_to_back();
    test_false_start();
    test_frame_error();
    test_reset_mid_frame();
    test_glitch();
    n_vec++; if (long_cnt != 0) begin n_err++; $display("FAIL strobe_width: got %0d long pulses want 0", long_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
